// File: rtl/alu_req_arbiter_if.sv
// Bundle between two ALU command requesters and the shared execution units.
// REQn: the requester holds VALID with stable A/B/FUN until it sees READY; one
// operation transfers in each cycle where VALID && READY. RSPn: one-cycle VALID
// pulse with DATA, no backpressure. Unit side: one-cycle *_EN, UNIT_VALID completes.
interface alu_req_arbiter_if #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 16
);
    logic                 REQ0_VALID;
    logic [A_WIDTH-1:0]   REQ0_A;
    logic [B_WIDTH-1:0]   REQ0_B;
    logic [3:0]           REQ0_FUN;
    logic                 REQ0_READY;
    logic                 REQ1_VALID;
    logic [A_WIDTH-1:0]   REQ1_A;
    logic [B_WIDTH-1:0]   REQ1_B;
    logic [3:0]           REQ1_FUN;
    logic                 REQ1_READY;
    logic                 RSP0_VALID;
    logic [OUT_WIDTH-1:0] RSP0_DATA;
    logic                 RSP1_VALID;
    logic [OUT_WIDTH-1:0] RSP1_DATA;
    logic [A_WIDTH-1:0]   ALU_A;
    logic [B_WIDTH-1:0]   ALU_B;
    logic [1:0]           ALU_FUN;
    logic                 ARITH_EN;
    logic                 LOGIC_EN;
    logic                 CMP_EN;
    logic                 SHIFT_EN;
    logic [OUT_WIDTH-1:0] UNIT_OUT;
    logic                 UNIT_VALID;
    logic                 BUSY;
    logic                 ERR;

    modport slave (
        input  REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUN,
        input  REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUN,
        input  UNIT_OUT, UNIT_VALID,
        output REQ0_READY, REQ1_READY,
        output RSP0_VALID, RSP0_DATA, RSP1_VALID, RSP1_DATA,
        output ALU_A, ALU_B, ALU_FUN,
        output ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN,
        output BUSY, ERR
    );

    modport master (
        output REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUN,
        output REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUN,
        output UNIT_OUT, UNIT_VALID,
        input  REQ0_READY, REQ1_READY,
        input  RSP0_VALID, RSP0_DATA, RSP1_VALID, RSP1_DATA,
        input  ALU_A, ALU_B, ALU_FUN,
        input  ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN,
        input  BUSY, ERR
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin scheduler sharing the ALU units between two requesters (IDLE/ISSUE/WAIT).
// Define ALU_TIMEOUT_EN to force completion with ERR after TIMEOUT silent WAIT cycles.
module alu_req_arbiter #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 16,
    parameter int TIMEOUT   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    alu_req_arbiter_if.slave bus,
    output logic [1:0]       state_dbg
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]           state;
    logic                 last_grant;
    logic                 owner;
    logic                 grant0;
    logic                 grant1;
    logic [A_WIDTH-1:0]   a_q;
    logic [B_WIDTH-1:0]   b_q;
    logic [3:0]           fun_q;
    logic                 expire;
    logic                 done;
    logic [OUT_WIDTH-1:0] result;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("alu_req_arbiter: TIMEOUT must be at least 1");
    end

    // Contention goes to the port that did not own the previous operation.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (bus.REQ0_VALID && bus.REQ1_VALID) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.REQ0_VALID;
                grant1 = bus.REQ1_VALID;
            end
        end
    end

`ifdef ALU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    // A UNIT_VALID arriving on the expiry cycle wins over the timeout.
    assign expire = (state == WAIT) && !bus.UNIT_VALID && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wait_cnt <= '0;
        end else if ((state == WAIT) && !bus.UNIT_VALID && !expire) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign expire = 1'b0;
`endif

    assign done   = (state == WAIT) && (bus.UNIT_VALID || expire);
    assign result = bus.UNIT_VALID ? bus.UNIT_OUT : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            fun_q          <= '0;
            bus.RSP0_VALID <= 1'b0;
            bus.RSP0_DATA  <= '0;
            bus.RSP1_VALID <= 1'b0;
            bus.RSP1_DATA  <= '0;
            bus.ERR        <= 1'b0;
        end else begin
            bus.RSP0_VALID <= 1'b0;
            bus.RSP1_VALID <= 1'b0;
            bus.ERR        <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner <= grant1;
                        a_q   <= grant1 ? bus.REQ1_A   : bus.REQ0_A;
                        b_q   <= grant1 ? bus.REQ1_B   : bus.REQ0_B;
                        fun_q <= grant1 ? bus.REQ1_FUN : bus.REQ0_FUN;
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (done) begin
                        if (owner) begin
                            bus.RSP1_VALID <= 1'b1;
                            bus.RSP1_DATA  <= result;
                        end else begin
                            bus.RSP0_VALID <= 1'b1;
                            bus.RSP0_DATA  <= result;
                        end
                        bus.ERR    <= expire;
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.REQ0_READY = grant0;
    assign bus.REQ1_READY = grant1;
    assign bus.ALU_A      = a_q;
    assign bus.ALU_B      = b_q;
    assign bus.ALU_FUN    = fun_q[1:0];
    assign bus.ARITH_EN   = (state == ISSUE) && (fun_q[3:2] == 2'b00);
    assign bus.LOGIC_EN   = (state == ISSUE) && (fun_q[3:2] == 2'b01);
    assign bus.CMP_EN     = (state == ISSUE) && (fun_q[3:2] == 2'b10);
    assign bus.SHIFT_EN   = (state == ISSUE) && (fun_q[3:2] == 2'b11);
    assign bus.BUSY       = (state != IDLE);
    assign state_dbg      = state;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed and randomized bench for alu_req_arbiter with behavioural unit and scoreboard.
module tb_alu_req_arbiter;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int OW = 16;
    localparam int TO = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic [1:0] state_dbg;
    always #5 CLK = ~CLK;

    alu_req_arbiter_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus ();

    alu_req_arbiter #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .state_dbg(state_dbg)
    );

    logic          v[2];
    logic [AW-1:0] ra[2];
    logic [BW-1:0] rb[2];
    logic [3:0]    rf[2];
    int            refill[2];
    logic          acc[2];
    logic          uv, inj_v;
    logic [OW-1:0] uo, inj_d, held;
    int            unit_delay = 0;
    int            cnt;
    bit            unit_mute = 0;
    bit            expect_to = 0;
    int            checks = 0;
    int            failures = 0;
    int            model_last = 1;
    int            grant_log[$];
    logic [OW-1:0] exp_q0[$];
    logic [OW-1:0] exp_q1[$];

    assign bus.REQ0_VALID = v[0];
    assign bus.REQ0_A     = ra[0];
    assign bus.REQ0_B     = rb[0];
    assign bus.REQ0_FUN   = rf[0];
    assign bus.REQ1_VALID = v[1];
    assign bus.REQ1_A     = ra[1];
    assign bus.REQ1_B     = rb[1];
    assign bus.REQ1_FUN   = rf[1];
    assign bus.UNIT_VALID = uv | inj_v;
    assign bus.UNIT_OUT   = inj_v ? inj_d : uo;

    function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // Behavioural execution units: sel 0 arith, 1 logic, 2 cmp, 3 shift.
    function automatic logic [OW-1:0] unit_fn(logic [1:0] sel, logic [1:0] fn,
                                              logic [AW-1:0] a, logic [BW-1:0] b);
        logic [OW-1:0] x, y, r;
        x = OW'(a);
        y = OW'(b);
        r = '0;
        case (sel)
            2'd0: case (fn) 2'd0: r = x + y; 2'd1: r = x - y; 2'd2: r = x * y; default: r = x + y + OW'(1); endcase
            2'd1: case (fn) 2'd0: r = x & y; 2'd1: r = x | y; 2'd2: r = x ^ y; default: r = ~x; endcase
            2'd2: case (fn)
                2'd0: r = (a != b) ? OW'(4) : '0;
                2'd1: r = (a == b) ? OW'(1) : '0;
                2'd2: r = (a > b) ? OW'(2) : '0;
                default: r = (a < b) ? OW'(3) : '0;
            endcase
            default: case (fn) 2'd0: r = x << b[2:0]; 2'd1: r = x >> b[2:0]; 2'd2: r = (x << 8) | y; default: r = x << b[3:0]; endcase
        endcase
        return r;
    endfunction

    // Unit model: result registered after the enable, optionally delayed or muted.
    logic          en_any;
    logic [1:0]    en_sel;
    assign en_any = bus.ARITH_EN | bus.LOGIC_EN | bus.CMP_EN | bus.SHIFT_EN;
    assign en_sel = bus.SHIFT_EN ? 2'd3 : bus.CMP_EN ? 2'd2 : bus.LOGIC_EN ? 2'd1 : 2'd0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            uv <= 1'b0; uo <= '0; held <= '0; cnt <= 0;
        end else begin
            uv <= 1'b0;
            if (en_any && !unit_mute) begin
                if (unit_delay == 0) begin
                    uv <= 1'b1;
                    uo <= unit_fn(en_sel, bus.ALU_FUN, bus.ALU_A, bus.ALU_B);
                end else begin
                    cnt  <= unit_delay;
                    held <= unit_fn(en_sel, bus.ALU_FUN, bus.ALU_A, bus.ALU_B);
                end
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    uv <= 1'b1;
                    uo <= held;
                end
            end
        end
    end

    // Monitor and scoreboard: round-robin grant model, issue decode, response data.
    logic          issue_pend = 1'b0;
    logic [3:0]    issue_fun;
    logic [AW-1:0] issue_a;
    logic [BW-1:0] issue_b;
    logic [3:0]    en_vec;
    int            got, exp_g;

    always @(negedge CLK) begin
        if (!RST) begin
            exp_q0.delete(); exp_q1.delete();
            model_last = 1; issue_pend = 1'b0; acc[0] = 1'b0; acc[1] = 1'b0;
        end else begin
            if (bus.RSP0_VALID) begin
                if (exp_q0.size() == 0) check("rsp0_unexpected", 1, 0);
                else check("rsp0_data", bus.RSP0_DATA, exp_q0.pop_front());
                model_last = 0;
            end
            if (bus.RSP1_VALID) begin
                if (exp_q1.size() == 0) check("rsp1_unexpected", 1, 0);
                else check("rsp1_data", bus.RSP1_DATA, exp_q1.pop_front());
                model_last = 1;
            end
            check("ready_excl", bus.REQ0_READY & bus.REQ1_READY, 0);
            en_vec = {bus.SHIFT_EN, bus.CMP_EN, bus.LOGIC_EN, bus.ARITH_EN};
            if (issue_pend) begin
                check("issue_en", en_vec, 4'b0001 << issue_fun[3:2]);
                check("issue_fun", bus.ALU_FUN, issue_fun[1:0]);
                check("issue_a", bus.ALU_A, issue_a);
                check("issue_b", bus.ALU_B, issue_b);
                issue_pend = 1'b0;
            end else begin
                check("idle_en", en_vec, 0);
            end
`ifndef ALU_TIMEOUT_EN
            check("err_zero", bus.ERR, 0);
`endif
            if (bus.REQ0_READY || bus.REQ1_READY) begin
                got   = bus.REQ1_READY ? 1 : 0;
                exp_g = (v[0] && v[1]) ? 1 - model_last : (v[1] ? 1 : 0);
                check("rr_grant", got, exp_g);
                check("ready_has_req", v[got], 1);
                grant_log.push_back(got);
                acc[got] = 1'b1;
                if (got == 0) exp_q0.push_back(expect_to ? '0 : unit_fn(rf[0][3:2], rf[0][1:0], ra[0], rb[0]));
                else          exp_q1.push_back(expect_to ? '0 : unit_fn(rf[1][3:2], rf[1][1:0], ra[1], rb[1]));
                issue_pend = 1'b1;
                issue_fun  = rf[got];
                issue_a    = ra[got];
                issue_b    = rb[got];
            end
        end
    end

    task automatic set_req(int p, logic [AW-1:0] a, logic [BW-1:0] b, logic [3:0] f);
        v[p] = 1'b1; ra[p] = a; rb[p] = b; rf[p] = f;
    endtask

    task automatic new_req(int p);
        set_req(p, AW'($urandom), BW'($urandom), 4'($urandom_range(0, 15)));
    endtask

    // Advance to just after the next rising edge; retire or refill accepted requests.
    task automatic tick();
        @(posedge CLK);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
                acc[p] = 1'b0;
                if (refill[p] > 0) begin
                    refill[p]--;
                    new_req(p);
                end else begin
                    v[p] = 1'b0;
                end
            end
        end
    endtask

    task automatic reset_dut();
        RST = 1'b0;
        v[0] = 1'b0; v[1] = 1'b0; refill[0] = 0; refill[1] = 0; inj_v = 1'b0;
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    task automatic check_all_zero(string pfx);
        check({pfx, "_ready0"}, bus.REQ0_READY, 0);
        check({pfx, "_ready1"}, bus.REQ1_READY, 0);
        check({pfx, "_rsp0_v"}, bus.RSP0_VALID, 0);
        check({pfx, "_rsp1_v"}, bus.RSP1_VALID, 0);
        check({pfx, "_rsp0_d"}, bus.RSP0_DATA, 0);
        check({pfx, "_rsp1_d"}, bus.RSP1_DATA, 0);
        check({pfx, "_alu_a"}, bus.ALU_A, 0);
        check({pfx, "_alu_b"}, bus.ALU_B, 0);
        check({pfx, "_alu_fun"}, bus.ALU_FUN, 0);
        check({pfx, "_en"}, {bus.SHIFT_EN, bus.CMP_EN, bus.LOGIC_EN, bus.ARITH_EN}, 0);
        check({pfx, "_busy"}, bus.BUSY, 0);
        check({pfx, "_err"}, bus.ERR, 0);
    endtask

    task automatic drain(string tag, int budget);
        int c = 0;
        @(negedge CLK);
        #1;
        while ((bus.BUSY || v[0] || v[1] || exp_q0.size() != 0 || exp_q1.size() != 0) && c < budget) begin
            tick();
            @(negedge CLK);
            #1;
            c++;
        end
        check(tag, c < budget, 1);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OW-1:0] r;
        v[0] = 1'b0; v[1] = 1'b0; acc[0] = 1'b0; acc[1] = 1'b0;
        refill[0] = 0; refill[1] = 0;
        ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0; rf[0] = '0; rf[1] = '0;
        inj_v = 1'b0; inj_d = '0;

        // Outputs while reset is asserted.
        repeat (2) @(negedge CLK);
        check_all_zero("rst");
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // Single CMP equality request on port 0.
        set_req(0, 8'd5, 8'd5, 4'b1001);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("t1_ready0", bus.REQ0_READY, c == 0);
            check("t1_cmp_en", bus.CMP_EN, c == 1);
            if (c == 1) check("t1_alu_fun", bus.ALU_FUN, 2'b01);
            check("t1_rsp0_v", bus.RSP0_VALID, c == 3);
            check("t1_rsp1_v", bus.RSP1_VALID, 0);
            if (c >= 3) check("t1_rsp0_d", bus.RSP0_DATA, 1);
            check("t1_busy", bus.BUSY, (c == 1) || (c == 2));
            tick();
        end

        // Both ports valid straight out of reset: port 0 first.
        reset_dut();
        set_req(0, 8'd9, 8'd3, 4'b1010);
        set_req(1, 8'd2, 8'd7, 4'b1011);
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            check("t2_ready0", bus.REQ0_READY, c == 0);
            check("t2_ready1", bus.REQ1_READY, c == 3);
            check("t2_rsp0_v", bus.RSP0_VALID, c == 3);
            check("t2_rsp1_v", bus.RSP1_VALID, c == 6);
            if (c == 3) check("t2_rsp0_d", bus.RSP0_DATA, 2);
            if (c == 6) check("t2_rsp1_d", bus.RSP1_DATA, 3);
            tick();
        end

        // Continuous contention: six grants alternate.
        reset_dut();
        grant_log.delete();
        refill[0] = 2; refill[1] = 2;
        new_req(0);
        new_req(1);
        for (int c = 0; c < 40 && grant_log.size() < 6; c++) tick();
        check("t3_grant_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) check("t3_order", (i < grant_log.size()) ? grant_log[i] : 9, i % 2);
        drain("t3_drain", 50);

        // Unresponsive unit.
        reset_dut();
        unit_mute = 1;
`ifdef ALU_TIMEOUT_EN
        r = unit_fn(2'd0, 2'd2, 8'h12, 8'h34);
        set_req(0, 8'h12, 8'h34, 4'b0010);
        for (int c = 0; c < 12; c++) begin
            if (c == 9) begin inj_v = 1'b1; inj_d = r; end
            else inj_v = 1'b0;
            @(negedge CLK);
            check("t4p_err", bus.ERR, 0);
            check("t4p_rsp0_v", bus.RSP0_VALID, c == 10);
            if (c == 10) check("t4p_rsp0_d", bus.RSP0_DATA, r);
            tick();
        end
        inj_v = 1'b0;
        expect_to = 1;
        set_req(0, 8'h56, 8'h78, 4'b0010);
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            check("t4_err", bus.ERR, c == 10);
            check("t4_rsp0_v", bus.RSP0_VALID, c == 10);
            if (c == 10) check("t4_rsp0_d", bus.RSP0_DATA, 0);
            check("t4_busy", bus.BUSY, (c >= 1) && (c <= 9));
            tick();
        end
        expect_to = 0;
`else
        r = unit_fn(2'd0, 2'd2, 8'h12, 8'h34);
        set_req(0, 8'h12, 8'h34, 4'b0010);
        for (int c = 0; c < 24; c++) begin
            if (c == 20) begin inj_v = 1'b1; inj_d = r; end
            else inj_v = 1'b0;
            @(negedge CLK);
            check("t4_busy", bus.BUSY, (c >= 1) && (c <= 20));
            check("t4_rsp0_v", bus.RSP0_VALID, c == 21);
            if (c == 21) check("t4_rsp0_d", bus.RSP0_DATA, r);
            tick();
        end
        inj_v = 1'b0;
`endif
        unit_mute = 0;

        // Reset while waiting on a slow unit aborts silently.
        reset_dut();
        unit_delay = 5;
        set_req(0, 8'h21, 8'h43, 4'b0110);
        repeat (3) tick();
        RST = 1'b0;
        @(negedge CLK);
        check_all_zero("t5");
        @(posedge CLK);
        #1;
        RST = 1'b1;
        unit_delay = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            check("t5_rsp0_v", bus.RSP0_VALID, 0);
            check("t5_rsp1_v", bus.RSP1_VALID, 0);
            check("t5_busy", bus.BUSY, 0);
            tick();
        end
        set_req(0, 8'd3, 8'd4, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("t5_after_rsp0_v", bus.RSP0_VALID, c == 3);
            if (c == 3) check("t5_after_rsp0_d", bus.RSP0_DATA, 7);
            tick();
        end

        // Stray UNIT_VALID while idle.
        inj_v = 1'b1;
        inj_d = 16'hBEEF;
        @(negedge CLK);
        check("t6_busy_pulse", bus.BUSY, 0);
        tick();
        inj_v = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            check("t6_rsp0_v", bus.RSP0_VALID, 0);
            check("t6_rsp1_v", bus.RSP1_VALID, 0);
            check("t6_busy", bus.BUSY, 0);
            tick();
        end

        // Randomized traffic with varying unit latency.
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            tick();
            unit_delay = $urandom_range(0, 3);
            for (int p = 0; p < 2; p++)
                if (!v[p] && !acc[p] && $urandom_range(0, 2) == 0) new_req(p);
        end
        drain("t7_drain", 100);

        check("end_q0_empty", exp_q0.size(), 0);
        check("end_q1_empty", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
